// File: rtl/multdiv_sequencer.sv
// Sequencer for the shared multi-cycle multiply/divide unit in the execute stage.
// Starts the unit, counts its latency while stalling the front end, then presents the result for one cycle.
module multdiv_sequencer #(
  parameter int MULT_LAT = 32,
  parameter int DIV_LAT  = 32,
  parameter int CNT_W    = 6
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ex_mult,
  input  logic        i_ex_div,
  input  logic [4:0]  i_ex_rd,
  input  logic        i_flush,
  input  logic [31:0] i_unit_result,
  input  logic        i_unit_exception,
  output logic        o_unit_start,
  output logic        o_unit_op,
  output logic        o_unit_abort,
  output logic        o_stall,
  output logic        o_em_bubble,
  output logic        o_result_valid,
  output logic [31:0] o_result_data,
  output logic [4:0]  o_result_rd,
  output logic        o_result_exception,
  output logic        o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [CNT_W-1:0] MULT_INIT = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_INIT  = CNT_W'(DIV_LAT - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_unit_op;
  logic [31:0]       r_result_data;
  logic [4:0]        r_result_rd;
  logic              r_result_exception;

  logic w_req;
  logic w_op_div;
  logic w_accept;
  logic w_start;
  logic w_abort;
  logic w_stall;
  logic w_bubble;
  logic w_valid;

  // mult has priority when both decode flags are set
  assign w_req    = (i_ex_mult | i_ex_div) & ~i_flush;
  assign w_op_div = ~i_ex_mult & i_ex_div;
  assign w_accept = (r_state == S_IDLE) & w_req;

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_abort      = 1'b0;
    w_stall      = 1'b0;
    w_bubble     = 1'b0;
    w_valid      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_start      = 1'b1;
          w_stall      = 1'b1;
          w_bubble     = 1'b1;
          w_state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        w_stall  = 1'b1;
        w_bubble = 1'b1;
        if (i_flush) begin
          w_abort      = 1'b1;
          w_state_next = S_IDLE;
        end else if (r_cnt == '0) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        // the finished instruction is still in execute, so no new accept here
        w_valid      = ~i_flush;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state            <= S_IDLE;
      r_cnt              <= '0;
      r_unit_op          <= 1'b0;
      r_result_data      <= '0;
      r_result_rd        <= '0;
      r_result_exception <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_unit_op   <= w_op_div;
            r_result_rd <= i_ex_rd;
            r_cnt       <= w_op_div ? DIV_INIT : MULT_INIT;
          end
        end
        S_BUSY: begin
          if (i_flush) begin
            r_cnt     <= '0;
            r_unit_op <= 1'b0;
          end else if (r_cnt == '0) begin
            r_result_data      <= i_unit_result;
            r_result_exception <= i_unit_exception;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE:  r_unit_op <= 1'b0;
        default: r_unit_op <= 1'b0;
      endcase
    end
  end

  // combinational strobes are forced low while reset is held
  assign o_unit_start       = i_rst_n & w_start;
  assign o_unit_abort       = i_rst_n & w_abort;
  assign o_stall            = i_rst_n & w_stall;
  assign o_em_bubble        = i_rst_n & w_bubble;
  assign o_result_valid     = i_rst_n & w_valid;
  assign o_unit_op          = i_rst_n & (w_accept ? w_op_div : r_unit_op);
  assign o_busy             = i_rst_n & (r_state != S_IDLE);
  assign o_result_data      = r_result_data;
  assign o_result_rd        = r_result_rd;
  assign o_result_exception = r_result_exception;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Scoreboard bench for multdiv_sequencer with MULT_LAT=4, DIV_LAT=6.
module tb_multdiv_sequencer;

  localparam int MULT_LAT = 4;
  localparam int DIV_LAT  = 6;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        exc;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_mult, ex_div, flush, unit_exception;
  logic [4:0]  ex_rd;
  logic [31:0] unit_result;
  logic        unit_start, unit_op, unit_abort, stall, em_bubble, result_valid;
  logic [31:0] result_data;
  logic [4:0]  result_rd;
  logic        result_exception, busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  res_t sb_q[$];

  always #5 clk = ~clk;

  multdiv_sequencer #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_ex_mult(ex_mult), .i_ex_div(ex_div), .i_ex_rd(ex_rd), .i_flush(flush),
    .i_unit_result(unit_result), .i_unit_exception(unit_exception),
    .o_unit_start(unit_start), .o_unit_op(unit_op), .o_unit_abort(unit_abort),
    .o_stall(stall), .o_em_bubble(em_bubble), .o_result_valid(result_valid),
    .o_result_data(result_data), .o_result_rd(result_rd),
    .o_result_exception(result_exception), .o_busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // result monitor: every result_valid must match the oldest outstanding expectation
  always @(negedge clk) begin
    res_t e;
    if (rst_n && result_valid) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("res_data", result_data, e.data);
        check_eq("res_rd", {27'd0, result_rd}, {27'd0, e.rd});
        check_eq("res_exc", {31'd0, result_exception}, {31'd0, e.exc});
        $display("result rd=%0d data=0x%08h exc=%0b (exp rd=%0d data=0x%08h exc=%0b)",
                 result_rd, result_data, result_exception, e.rd, e.data, e.exc);
      end
    end
    if (unit_start && unit_abort) check_eq("start_abort_excl", 32'd1, 32'd0);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      cyc();
      ex_mult = 1'b0; ex_div = 1'b0; flush = 1'b0;
      @(negedge clk);
    end
  endtask

  // full mult/div transaction; instruction stays in execute through DONE (D/E is frozen)
  task automatic run_op(input logic m, input logic d, input logic [4:0] rd,
                        input logic [31:0] data, input logic exc, input int lat);
    logic op_exp;
    op_exp = d & ~m;
    cyc();
    ex_mult = m; ex_div = d; ex_rd = rd; flush = 1'b0;
    unit_result = $urandom; unit_exception = ~exc;
    sb_q.push_back({data, rd, exc});
    @(negedge clk);
    check_eq("acc_start", {31'd0, unit_start}, 32'd1);
    check_eq("acc_stall", {31'd0, stall}, 32'd1);
    check_eq("acc_bubble", {31'd0, em_bubble}, 32'd1);
    check_eq("acc_op", {31'd0, unit_op}, {31'd0, op_exp});
    check_eq("acc_busy", {31'd0, busy}, 32'd0);
    for (int c = 1; c <= lat; c++) begin
      cyc();
      unit_result    = (c == lat) ? data : $urandom;
      unit_exception = (c == lat) ? exc : ~exc;
      @(negedge clk);
      check_eq("busy_stall", {31'd0, stall}, 32'd1);
      check_eq("busy_bubble", {31'd0, em_bubble}, 32'd1);
      check_eq("busy_start", {31'd0, unit_start}, 32'd0);
      check_eq("busy_busy", {31'd0, busy}, 32'd1);
      check_eq("busy_op", {31'd0, unit_op}, {31'd0, op_exp});
      check_eq("busy_valid", {31'd0, result_valid}, 32'd0);
    end
    cyc();
    unit_result = $urandom; unit_exception = ~exc;
    @(negedge clk);
    check_eq("done_valid", {31'd0, result_valid}, 32'd1);
    check_eq("done_stall", {31'd0, stall}, 32'd0);
    check_eq("done_bubble", {31'd0, em_bubble}, 32'd0);
    check_eq("done_start", {31'd0, unit_start}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_outs"},
             {21'd0, unit_start, unit_op, unit_abort, stall, em_bubble,
              result_valid, result_exception, busy, result_rd != 5'd0,
              result_data != 32'd0, 1'b0}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; ex_mult = 1'b1; ex_div = 1'b0; ex_rd = 5'd0; flush = 1'b0;
    unit_result = 32'd0; unit_exception = 1'b0;
    #12;
    check_all_zero("reset");
    ex_mult = 1'b0;
    cyc();
    rst_n = 1'b1;
    idle(2);

    // single multiply
    run_op(1'b1, 1'b0, 5'd3, 32'h0000_0042, 1'b0, MULT_LAT);
    idle(1);
    // divide with exception
    run_op(1'b0, 1'b1, 5'd17, 32'hDEAD_0001, 1'b1, DIV_LAT);
    idle(1);
    // back-to-back multiplies: second accepted in the IDLE cycle after DONE
    run_op(1'b1, 1'b0, 5'd4, 32'h1234_5678, 1'b0, MULT_LAT);
    run_op(1'b1, 1'b0, 5'd5, 32'h8765_4321, 1'b0, MULT_LAT);
    idle(1);

    // flush during BUSY
    cyc(); ex_mult = 1'b1; ex_rd = 5'd7;
    @(negedge clk);
    check_eq("fl_start", {31'd0, unit_start}, 32'd1);
    cyc();
    @(negedge clk);
    cyc(); flush = 1'b1;
    @(negedge clk);
    check_eq("fl_abort", {31'd0, unit_abort}, 32'd1);
    check_eq("fl_stall", {31'd0, stall}, 32'd1);
    cyc(); flush = 1'b0; ex_mult = 1'b0;
    @(negedge clk);
    check_eq("fl_after_stall", {31'd0, stall}, 32'd0);
    check_eq("fl_after_busy", {31'd0, busy}, 32'd0);
    check_eq("fl_after_abort", {31'd0, unit_abort}, 32'd0);
    idle(8);

    // reset during BUSY, with a request still present
    cyc(); ex_mult = 1'b1; ex_rd = 5'd9;
    @(negedge clk);
    check_eq("rs_start", {31'd0, unit_start}, 32'd1);
    cyc(); @(negedge clk);
    cyc(); @(negedge clk);
    cyc(); rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    check_all_zero("midreset_hold");
    cyc(); ex_mult = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    check_eq("rs_after_busy", {31'd0, busy}, 32'd0);
    run_op(1'b1, 1'b0, 5'd10, 32'hCAFE_BABE, 1'b0, MULT_LAT);
    idle(1);

    // mult and div together: mult wins
    run_op(1'b1, 1'b1, 5'd31, 32'h0BAD_F00D, 1'b0, MULT_LAT);
    idle(1);

    // flush in IDLE suppresses accept
    cyc(); ex_mult = 1'b1; flush = 1'b1;
    @(negedge clk);
    check_eq("idle_flush_start", {31'd0, unit_start}, 32'd0);
    check_eq("idle_flush_stall", {31'd0, stall}, 32'd0);
    cyc(); ex_mult = 1'b0; flush = 1'b0;
    @(negedge clk);
    check_eq("idle_flush_busy", {31'd0, busy}, 32'd0);

    idle(3);
    check_eq("sb_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
